// File: rtl/round_sat_pipe.sv
// Elastic two-stage rounding quantizer: drops NBITS LSBs with a per-word
// rounding mode, narrows to DIN-NBITS bits and saturates on rounding carry.
module round_sat_pipe #(
  parameter int DIN = 16,
  parameter int NBITS = 0,
  parameter int SIGNED = 0,
  parameter int CNT_W = 16,
  localparam int DOUT = DIN - NBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIN-1:0]   din_data,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [1:0]       mode,
  output logic [DOUT-1:0]  dout_data,
  output logic             dout_valid,
  input  logic             dout_ready,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_cnt
);

  // Streams transfer a word on a rising edge where valid && ready; a producer
  // never lowers valid or changes data while waiting, and valid never looks
  // at ready.

  localparam int HSH = (NBITS > 0) ? NBITS - 1 : 0;
  localparam logic [DIN:0] ONE = (DIN+1)'(1);
  localparam logic [DIN:0] H = (NBITS > 0) ? (ONE << HSH) : '0;
  localparam logic [DOUT-1:0] UMAX = '1;
  localparam logic [DOUT-1:0] SMAX = ~(DOUT'(1) << (DOUT - 1));
  localparam logic [DOUT-1:0] MAXV = (SIGNED != 0) ? SMAX : UMAX;

  logic            s1_valid;
  logic [DOUT:0]   s1_q;
  logic            s2_sat;
  logic            s1_rdy;
  logic            s2_rdy;
  logic [DIN:0]    ext;
  logic [DIN:0]    inc;
  logic [DIN:0]    sum;
  logic [DOUT:0]   q_next;
  logic            k;
  logic            msb;
  logic            ovf;

  assign s2_rdy    = !dout_valid || dout_ready;
  assign s1_rdy    = !s1_valid || s2_rdy;
  assign din_ready = s1_rdy;

  always_comb begin
    msb = din_data[DIN-1];
    k   = din_data[NBITS];
    ext = {(SIGNED != 0) ? msb : 1'b0, din_data};
    inc = '0;
    if (NBITS > 0) begin
      case (mode)
        2'd1:    inc = H;
        2'd2:    inc = H - ONE + {{DIN{1'b0}}, k};
        2'd3:    inc = ((SIGNED != 0) && msb) ? H - ONE : H;
        default: inc = '0;
      endcase
    end
    sum    = ext + inc;
    q_next = (DOUT+1)'(sum >> NBITS);
  end

  // inc is never negative, so only the positive limit can be crossed.
  always_comb begin
    if (SIGNED != 0) ovf = !s1_q[DOUT] && s1_q[DOUT-1];
    else             ovf = s1_q[DOUT];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid   <= 1'b0;
      s1_q       <= '0;
      dout_valid <= 1'b0;
      dout_data  <= '0;
      s2_sat     <= 1'b0;
      sat_cnt    <= '0;
    end else begin
      if (s1_rdy) begin
        s1_valid <= din_valid;
        if (din_valid) s1_q <= q_next;
      end
      if (s2_rdy) begin
        dout_valid <= s1_valid;
        if (s1_valid) begin
          dout_data <= ovf ? MAXV : s1_q[DOUT-1:0];
          s2_sat    <= ovf;
        end
      end
      if (sat_clr)
        sat_cnt <= '0;
      else if (dout_valid && dout_ready && s2_sat && (sat_cnt != '1))
        sat_cnt <= sat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_round_sat_pipe.sv
// Directed bench for round_sat_pipe: unsigned, signed and pass-through
// instances sharing one clock and reset.
module tb_round_sat_pipe;

  logic clk;
  logic rst;
  logic [7:0] din_d [3];
  logic [1:0] md [3];
  logic       dv [3];
  logic       ordy [3];
  logic       sclr [3];

  wire        u_dr, s_dr, p_dr;
  wire        u_ov, s_ov, p_ov;
  wire [3:0]  u_od, s_od;
  wire [7:0]  p_od;
  wire [3:0]  u_cnt;
  wire [15:0] s_cnt, p_cnt;

  int n_vec;
  int n_err;
  logic [4:0] exp_q[$];

  // Narrow counter on the unsigned instance so the all-ones hold is reachable.
  round_sat_pipe #(.DIN(8), .NBITS(4), .SIGNED(0), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .din_data(din_d[0]), .din_valid(dv[0]), .din_ready(u_dr),
    .mode(md[0]), .dout_data(u_od), .dout_valid(u_ov), .dout_ready(ordy[0]),
    .sat_clr(sclr[0]), .sat_cnt(u_cnt));

  round_sat_pipe #(.DIN(8), .NBITS(4), .SIGNED(1), .CNT_W(16)) s_dut (
    .clk(clk), .rst(rst), .din_data(din_d[1]), .din_valid(dv[1]), .din_ready(s_dr),
    .mode(md[1]), .dout_data(s_od), .dout_valid(s_ov), .dout_ready(ordy[1]),
    .sat_clr(sclr[1]), .sat_cnt(s_cnt));

  round_sat_pipe #(.DIN(8), .NBITS(0), .SIGNED(0), .CNT_W(16)) p_dut (
    .clk(clk), .rst(rst), .din_data(din_d[2]), .din_valid(dv[2]), .din_ready(p_dr),
    .mode(md[2]), .dout_data(p_od), .dout_valid(p_ov), .dout_ready(ordy[2]),
    .sat_clr(sclr[2]), .sat_cnt(p_cnt));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] get_od(int sel);
    case (sel)
      0:       return {4'h0, u_od};
      1:       return {4'h0, s_od};
      default: return p_od;
    endcase
  endfunction

  function automatic logic get_ov(int sel);
    case (sel)
      0:       return u_ov;
      1:       return s_ov;
      default: return p_ov;
    endcase
  endfunction

  function automatic logic get_rdy(int sel);
    case (sel)
      0:       return u_dr;
      1:       return s_dr;
      default: return p_dr;
    endcase
  endfunction

  function automatic logic [15:0] get_cnt(int sel);
    case (sel)
      0:       return {12'h0, u_cnt};
      1:       return s_cnt;
      default: return p_cnt;
    endcase
  endfunction

  // Arithmetic rounding reference for the unsigned 8->4 instance: {sat, data}.
  function automatic logic [4:0] model_u(logic [7:0] d, logic [1:0] m);
    int base, frac, r;
    base = int'(d) / 16;
    frac = int'(d) % 16;
    r = base;
    case (m)
      2'd1, 2'd3: if (frac >= 8) r = r + 1;
      2'd2:       if (frac > 8 || (frac == 8 && (base % 2) == 1)) r = r + 1;
      default:    r = base;
    endcase
    if (r > 15) return 5'h1F;
    return {1'b0, r[3:0]};
  endfunction

  // Single word through one instance; entered and left just after a rising edge.
  task automatic xfer(input int sel, input logic [7:0] d, input logic [1:0] m,
                      output logic [7:0] o, output int lat);
    logic acc;
    int t;
    din_d[sel] = d;
    md[sel] = m;
    dv[sel] = 1'b1;
    ordy[sel] = 1'b1;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 20) begin
      @(negedge clk);
      acc = get_rdy(sel);
      t++;
    end
    @(posedge clk); #1;
    dv[sel] = 1'b0;
    o = 'x;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (get_ov(sel)) begin
        o = get_od(sel);
        lat = i;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_cnt(input int sel);
    sclr[sel] = 1'b1;
    @(posedge clk); #1;
    sclr[sel] = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    for (int s = 0; s < 3; s++) begin
      n_vec++;
      if (get_ov(s) !== 1'b0) begin n_err++; $display("FAIL reset_valid[%0d]: got %b expected 0", s, get_ov(s)); end
      n_vec++;
      if (get_od(s) !== 8'h00) begin n_err++; $display("FAIL reset_data[%0d]: got %h expected 00", s, get_od(s)); end
      n_vec++;
      if (get_cnt(s) !== 16'h0) begin n_err++; $display("FAIL reset_cnt[%0d]: got %h expected 0", s, get_cnt(s)); end
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (u_dr !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", u_dr); end
  endtask

  task automatic test_round_unsigned;
    logic [7:0] vd [4] = '{8'h18, 8'h28, 8'h38, 8'h37};
    logic [1:0] vm [4] = '{2'd1, 2'd2, 2'd2, 2'd0};
    logic [7:0] ve [4] = '{8'h02, 8'h02, 8'h04, 8'h03};
    logic [7:0] o;
    int lat;
    for (int i = 0; i < 4; i++) begin
      xfer(0, vd[i], vm[i], o, lat);
      n_vec++;
      if (o !== ve[i]) begin n_err++; $display("FAIL round_u[%0d]: got %h expected %h", i, o, ve[i]); end
      n_vec++;
      if (lat !== 2) begin n_err++; $display("FAIL latency_u[%0d]: got %0d expected 2", i, lat); end
    end
    n_vec++;
    if (u_cnt !== 4'h0) begin n_err++; $display("FAIL cnt_nosat: got %h expected 0", u_cnt); end
  endtask

  task automatic test_sat_unsigned;
    logic [7:0] o;
    int lat;
    xfer(0, 8'hF8, 2'd1, o, lat);
    n_vec++;
    if (o !== 8'h0F) begin n_err++; $display("FAIL sat_u_data: got %h expected 0f", o); end
    n_vec++;
    if (u_cnt !== 4'h1) begin n_err++; $display("FAIL sat_u_cnt: got %h expected 1", u_cnt); end
    xfer(0, 8'hF8, 2'd0, o, lat);
    n_vec++;
    if (o !== 8'h0F) begin n_err++; $display("FAIL trunc_f8: got %h expected 0f", o); end
    n_vec++;
    if (u_cnt !== 4'h1) begin n_err++; $display("FAIL trunc_cnt: got %h expected 1", u_cnt); end
  endtask

  task automatic test_signed;
    logic [7:0] vd [6] = '{8'hF8, 8'hF8, 8'h78, 8'h88, 8'h88, 8'h88};
    logic [1:0] vm [6] = '{2'd1, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1};
    logic [7:0] ve [6] = '{8'h00, 8'h0F, 8'h07, 8'h08, 8'h08, 8'h09};
    logic [7:0] o;
    int lat;
    for (int i = 0; i < 6; i++) begin
      xfer(1, vd[i], vm[i], o, lat);
      n_vec++;
      if (o !== ve[i]) begin n_err++; $display("FAIL round_s[%0d]: got %h expected %h", i, o, ve[i]); end
    end
    n_vec++;
    if (s_cnt !== 16'h1) begin n_err++; $display("FAIL sat_s_cnt: got %h expected 1", s_cnt); end
  endtask

  task automatic test_passthrough;
    logic [7:0] o;
    int lat;
    for (int m = 0; m < 4; m++) begin
      xfer(2, 8'hA5, 2'(m), o, lat);
      n_vec++;
      if (o !== 8'hA5) begin n_err++; $display("FAIL pass_mode[%0d]: got %h expected a5", m, o); end
    end
    xfer(2, 8'hFF, 2'd1, o, lat);
    n_vec++;
    if (o !== 8'hFF) begin n_err++; $display("FAIL pass_ff: got %h expected ff", o); end
    n_vec++;
    if (p_cnt !== 16'h0) begin n_err++; $display("FAIL pass_cnt: got %h expected 0", p_cnt); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] vd [8] = '{8'h18, 8'h28, 8'h38, 8'h37, 8'hF8, 8'h8C, 8'h47, 8'h59};
    logic [1:0] vm [8] = '{2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1};
    logic [3:0] ve [8] = '{4'h2, 4'h2, 4'h4, 4'h3, 4'hF, 4'h9, 4'h4, 4'h6};
    ordy[0] = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) begin
        din_d[0] = vd[i];
        md[0] = vm[i];
        dv[0] = 1'b1;
      end else begin
        dv[0] = 1'b0;
      end
      @(negedge clk);
      if (i < 8) begin
        n_vec++;
        if (u_dr !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, u_dr); end
      end
      if (i >= 2 && i < 10) begin
        n_vec++;
        if (u_ov !== 1'b1 || u_od !== ve[i-2])
          begin n_err++; $display("FAIL b2b_out[%0d]: got v=%b d=%h expected v=1 d=%h", i - 2, u_ov, u_od, ve[i-2]); end
      end else begin
        n_vec++;
        if (u_ov !== 1'b0) begin n_err++; $display("FAIL b2b_idle[%0d]: got %b expected 0", i, u_ov); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stream;
    int got, cyc, nsat, exp_cnt;
    logic prev_stall;
    logic [3:0] prev_d;
    logic [4:0] e;
    clear_cnt(0);
    exp_q.delete();
    got = 0;
    nsat = 0;
    prev_stall = 1'b0;
    prev_d = '0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          logic [7:0] d;
          logic [1:0] m;
          logic acc;
          int t;
          d = 8'($urandom_range(0, 255));
          m = 2'($urandom_range(0, 3));
          din_d[0] = d;
          md[0] = m;
          dv[0] = 1'b1;
          exp_q.push_back(model_u(d, m));
          acc = 1'b0;
          t = 0;
          while (!acc && t < 50) begin
            @(negedge clk);
            acc = u_dr;
            t++;
            @(posedge clk); #1;
          end
        end
        dv[0] = 1'b0;
      end
      begin
        cyc = 0;
        while (got < 100 && cyc < 3000) begin
          ordy[0] = 1'($urandom_range(0, 1));
          @(negedge clk);
          cyc++;
          if (prev_stall) begin
            n_vec++;
            if (u_ov !== 1'b1 || u_od !== prev_d)
              begin n_err++; $display("FAIL stall_hold: got v=%b d=%h expected v=1 d=%h", u_ov, u_od, prev_d); end
          end
          if (u_ov === 1'b1 && ordy[0]) begin
            n_vec++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL stream_extra: got %h expected no word", u_od);
            end else begin
              e = exp_q.pop_front();
              if (e[4]) nsat++;
              if (u_od !== e[3:0]) begin n_err++; $display("FAIL stream[%0d]: got %h expected %h", got, u_od, e[3:0]); end
            end
            got++;
          end
          prev_stall = (u_ov === 1'b1) && !ordy[0];
          prev_d = u_od;
          @(posedge clk); #1;
        end
      end
    join
    ordy[0] = 1'b1;
    n_vec++;
    if (got !== 100) begin n_err++; $display("FAIL stream_count: got %0d expected 100", got); end
    n_vec++;
    if (exp_q.size() !== 0) begin n_err++; $display("FAIL stream_left: got %0d expected 0", exp_q.size()); end
    exp_cnt = (nsat > 15) ? 15 : nsat;
    n_vec++;
    if (u_cnt !== 4'(exp_cnt)) begin n_err++; $display("FAIL stream_satcnt: got %0d expected %0d", u_cnt, exp_cnt); end
  endtask

  task automatic test_sat_count;
    logic [7:0] o;
    int lat;
    clear_cnt(0);
    n_vec++;
    if (u_cnt !== 4'h0) begin n_err++; $display("FAIL satcnt_clear: got %h expected 0", u_cnt); end
    for (int i = 0; i < 15; i++) xfer(0, 8'hF8, 2'd1, o, lat);
    n_vec++;
    if (u_cnt !== 4'hF) begin n_err++; $display("FAIL satcnt_full: got %h expected f", u_cnt); end
    xfer(0, 8'hF8, 2'd3, o, lat);
    n_vec++;
    if (u_cnt !== 4'hF) begin n_err++; $display("FAIL satcnt_hold: got %h expected f", u_cnt); end
    n_vec++;
    if (o !== 8'h0F) begin n_err++; $display("FAIL satcnt_data: got %h expected 0f", o); end
    din_d[0] = 8'hF8;
    md[0] = 2'd1;
    dv[0] = 1'b1;
    ordy[0] = 1'b0;
    @(posedge clk); #1;
    dv[0] = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (u_ov !== 1'b1) begin n_err++; $display("FAIL clr_stage: got %b expected 1", u_ov); end
    sclr[0] = 1'b1;
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    sclr[0] = 1'b0;
    n_vec++;
    if (u_cnt !== 4'h0) begin n_err++; $display("FAIL clr_priority: got %h expected 0", u_cnt); end
    n_vec++;
    if (u_ov !== 1'b0) begin n_err++; $display("FAIL clr_drain: got %b expected 0", u_ov); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] o;
    int lat;
    ordy[0] = 1'b0;
    din_d[0] = 8'h37;
    md[0] = 2'd0;
    dv[0] = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    dv[0] = 1'b0;
    n_vec++;
    if (u_ov !== 1'b1 || u_dr !== 1'b0)
      begin n_err++; $display("FAIL full_before_rst: got v=%b r=%b expected v=1 r=0", u_ov, u_dr); end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if (u_ov !== 1'b0) begin n_err++; $display("FAIL async_rst_valid: got %b expected 0", u_ov); end
    n_vec++;
    if (u_od !== 4'h0) begin n_err++; $display("FAIL async_rst_data: got %h expected 0", u_od); end
    n_vec++;
    if (u_dr !== 1'b1) begin n_err++; $display("FAIL async_rst_ready: got %b expected 1", u_dr); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (u_ov !== 1'b0) begin n_err++; $display("FAIL post_rst_idle[%0d]: got %b expected 0", i, u_ov); end
    end
    @(posedge clk); #1;
    xfer(0, 8'h18, 2'd1, o, lat);
    n_vec++;
    if (o !== 8'h02) begin n_err++; $display("FAIL post_rst_data: got %h expected 02", o); end
    n_vec++;
    if (lat !== 2) begin n_err++; $display("FAIL post_rst_latency: got %0d expected 2", lat); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      din_d[s] = '0;
      md[s] = '0;
      dv[s] = 1'b0;
      ordy[s] = 1'b0;
      sclr[s] = 1'b0;
    end
    test_reset;
    test_round_unsigned;
    test_sat_unsigned;
    test_signed;
    test_passthrough;
    test_back_to_back;
    test_stream;
    test_sat_count;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
